l1i_port_arb: RTL and testbench

L1I_PORT_ARB -- requirements
Module: l1i_port_arb

---
 rtl/l1i_port_arb.sv | 112 +++++++++++
 tb/tb_l1i_port_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1i_port_arb.sv
// Instruction-SRAM port arbiter: fetch (m0) and loader/debug (m1) share one SRAM port.
// Default priority is m0; m1 wins after STARVE_MAX consecutive lost arbitrations.
module l1i_port_arb #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_flag_i,
  input  logic          jump_flag_i,
  input  logic          m0_req_i,
  input  logic [AW-1:0] m0_addr_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  output logic [AW-1:0] m0_raddr_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_re_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0]    starve_q, starve_d;
  logic          m0_elig, m1_prio, m0_gnt, m1_gnt;
  logic          tag_valid_q, tag_owner_q, tag_write_q, tag_kill_q;
  logic [AW-1:0] tag_addr_q, tag_addr_d;

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    m0_elig = m0_req_i & ~hold_flag_i;
    m1_prio = (starve_q == StarveMax);
    m1_gnt  = rst & m1_req_i & (~m0_elig | m1_prio);
    m0_gnt  = rst & m0_elig & ~m1_gnt;
  end

  assign m0_gnt_o = m0_gnt;
  assign m1_gnt_o = m1_gnt;

  always_comb begin
    if (!m1_req_i || m1_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_comb begin
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (m1_gnt) begin
      mem_re_o    = ~m1_we_i;
      mem_we_o    = m1_we_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
    end else if (m0_gnt) begin
      mem_re_o   = 1'b1;
      mem_addr_o = m0_addr_i;
    end
  end

  always_comb begin
    tag_addr_d = '0;
    if (m1_gnt) begin
      tag_addr_d = m1_addr_i;
    end else if (m0_gnt) begin
      tag_addr_d = m0_addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q    <= 4'd0;
      tag_valid_q <= 1'b0;
      tag_owner_q <= 1'b0;
      tag_write_q <= 1'b0;
      tag_kill_q  <= 1'b0;
      tag_addr_q  <= '0;
    end else begin
      starve_q    <= starve_d;
      tag_valid_q <= m0_gnt | m1_gnt;
      tag_owner_q <= m1_gnt;
      tag_write_q <= m1_gnt & m1_we_i;
      // A redirect during the grant cycle already dooms the fetch response.
      tag_kill_q  <= m0_gnt & jump_flag_i;
      tag_addr_q  <= tag_addr_d;
    end
  end

  always_comb begin
    m0_rvalid_o = rst & tag_valid_q & ~tag_owner_q & ~tag_kill_q & ~jump_flag_i;
    m1_rvalid_o = rst & tag_valid_q & tag_owner_q;
    m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    m0_raddr_o  = m0_rvalid_o ? tag_addr_q : '0;
    m1_rdata_o  = (m1_rvalid_o && !tag_write_q) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_l1i_port_arb.sv
// Randomised bench for l1i_port_arb: reference arbitration model feeds a response
// scoreboard that a separate monitor drains one entry per cycle.
module tb_l1i_port_arb;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hold_flag_i, jump_flag_i;
  logic          m0_req_i, m0_gnt_o, m0_rvalid_o;
  logic [AW-1:0] m0_addr_i, m0_raddr_o;
  logic [DW-1:0] m0_rdata_o;
  logic          m1_req_i, m1_we_i, m1_gnt_o, m1_rvalid_o;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_wdata_i, m1_rdata_o;
  logic          mem_re_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  l1i_port_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .hold_flag_i(hold_flag_i), .jump_flag_i(jump_flag_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_raddr_o(m0_raddr_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM on the shared port; unwritten words read as addr + 3.
  logic [31:0]  hw_mem [256];
  logic [255:0] hw_wr;
  always @(posedge clk) begin
    if (!rst) begin
      hw_wr <= '0;
    end else if (mem_we_o) begin
      hw_mem[mem_addr_o[9:2]] <= mem_wdata_o;
      hw_wr[mem_addr_o[9:2]]  <= 1'b1;
    end
    if (mem_re_o) begin
      mem_rdata_i <= hw_wr[mem_addr_o[9:2]] ? hw_mem[mem_addr_o[9:2]] : mem_addr_o + 32'd3;
    end else begin
      mem_rdata_i <= $urandom;
    end
  end

  typedef struct {
    int          owner;  // -1 none, 0 fetch, 1 loader
    logic [31:0] addr;
    logic [31:0] data;
    bit          kill;
  } rsp_t;

  rsp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          starve = 0;
  logic [31:0] ref_mem [256];
  bit          ref_wr  [256];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : a + 32'd3;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus: drive, model arbitration, check grant/mem port, queue response.
  task automatic drive(input bit r0, input logic [31:0] a0, input bit r1, input bit we,
                       input logic [31:0] a1, input logic [31:0] wd, input bit hold,
                       input bit jump);
    bit           el0, g0, g1;
    rsp_t         e;
    logic [127:0] exp, act;
    @(negedge clk);
    m0_req_i = r0; m0_addr_i = a0; m1_req_i = r1; m1_we_i = we;
    m1_addr_i = a1; m1_wdata_i = wd; hold_flag_i = hold; jump_flag_i = jump;
    el0 = r0 && !hold;
    g1  = rst && r1 && (!el0 || starve == SMAX);
    g0  = rst && el0 && !g1;
    if (!rst || !r1 || g1) starve = 0;
    else if (starve < 15) starve++;
    e.owner = -1; e.addr = 32'h0; e.data = 32'h0; e.kill = 1'b0;
    if (g0) begin
      e.owner = 0; e.addr = a0; e.data = ref_rd(a0); e.kill = jump;
    end else if (g1) begin
      e.owner = 1; e.addr = a1;
      e.data = we ? 32'h0 : ref_rd(a1);
      if (we) begin
        ref_mem[a1[9:2]] = wd;
        ref_wr[a1[9:2]]  = 1'b1;
      end
    end
    exp = 128'({g0, g1, g0 | (g1 & !we), g1 & we,
                g0 ? a0 : (g1 ? a1 : 32'h0), g1 ? wd : 32'h0});
    #1;
    act = 128'({m0_gnt_o, m1_gnt_o, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o});
    check("grant_mem", act, exp);
    q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic clear_ref();
    starve = 0;
    foreach (ref_wr[i]) ref_wr[i] = 1'b0;
  endtask

  // Pull reset between a grant and its response; everything must drop at once.
  task automatic mid_reset();
    logic [127:0] act;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    act = 128'({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m0_raddr_o,
                m1_rdata_o, mem_re_o, mem_we_o, mem_addr_o | mem_wdata_o});
    check("async_reset", act, 128'h0);
    foreach (q[i]) q[i].owner = -1;
    clear_ref();
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  // Monitor: the head entry is always the previous cycle's grant.
  initial begin
    rsp_t         e;
    bit           v0, v1;
    logic [127:0] exp, act;
    forever begin
      @(negedge clk); #2;
      if (q.size() > 0) begin
        e = q.pop_front();
      end else begin
        e.owner = -1; e.addr = 32'h0; e.data = 32'h0; e.kill = 1'b0;
      end
      v0  = (e.owner == 0) && !e.kill && !jump_flag_i;
      v1  = (e.owner == 1);
      exp = 128'({v0, v0 ? e.data : 32'h0, v0 ? e.addr : 32'h0, v1, v1 ? e.data : 32'h0});
      act = 128'({m0_rvalid_o, m0_rdata_o, m0_raddr_o, m1_rvalid_o, m1_rdata_o});
      check("response", act, exp);
    end
  end

  initial begin
    rsp_t        none;
    logic [31:0] ra, rb;
    none.owner = -1; none.addr = 32'h0; none.data = 32'h0; none.kill = 1'b0;
    q.push_back(none);
    clear_ref();
    m0_req_i = 1'b0; m0_addr_i = '0; m1_req_i = 1'b0; m1_we_i = 1'b0;
    m1_addr_i = '0; m1_wdata_i = '0; hold_flag_i = 1'b0; jump_flag_i = 1'b0;

    // Requests under reset must not be granted.
    repeat (3) drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h5, 1'b0, 1'b0);
    idle();
    release_reset();

    // Single fetch: 0x10 reads back 0x13.
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle();

    // Both held: four fetches, one loader grant, fetches resume.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom & 32'h3FC;
      rb = $urandom & 32'h3FC;
      drive(1'b1, ra, 1'b1, 1'b0, rb, 32'h0, 1'b0, 1'b0);
    end
    idle();

    // Redirect in the response cycle, then in the grant cycle.
    drive(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h28, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle();

    // Hold blocks fetch; loader write goes through, then reads it back.
    drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
    idle();

    // Alternating fetch/loader reads.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom & 32'h3FC;
      if (i % 2 == 0) drive(1'b1, ra, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      else            drive(1'b0, 32'h0, 1'b1, 1'b0, ra, 32'h0, 1'b0, 1'b0);
    end

    // Reset between grant and response.
    drive(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    mid_reset();
    drive(1'b1, 32'h34, 1'b1, 1'b0, 32'h38, 32'h0, 1'b0, 1'b0);
    idle();
    release_reset();
    idle();
    idle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom & 32'h3FC,
            $urandom_range(0, 9) < 5, $urandom_range(0, 1) == 1, $urandom & 32'h3FC,
            $urandom, $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 3);
    end
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
